main_mem: RTL
=============

Name: main_mem

Overview:
- Behavioural/synthesizable main-memory model directly downstream of the cache hierarchy top level.
- Consumes the L2 miss/writeback stream (mem_req_*) and produces read fills (mem_resp_*).
- Buffers requests in an in-order queue and services them one at a time with a fixed, parameterised access latency.
- Used as the memory endpoint in system simulation and FPGA bring-up.

Parameters:
- MEM_LINES, 1024, number of cacheline entries in the backing array; power of two, >= 2.
- LATENCY, 4, wait cycles per access; integer >= 1.
- QUEUE_DEPTH, 4, request FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mem_req_valid  input  1  request present.
- mem_req_rw  input  1  0 = read, 1 = write.
- mem_req_addr  input  `ADDR_BITS-`OFFSET_BITS  line address.
- mem_req_data  input  `CACHELINE_BITS  write line data; ignored for reads.
- mem_req_ready  output  1  queue can accept a request.
- mem_resp_valid  output  1  read data valid, one-cycle pulse.
- mem_resp_data  output  `CACHELINE_BITS  read line data.

Behaviour:
- Design: one clock domain, clk. reset_n is asynchronous and active-low.
- Reset values:
  - mem_req_ready = 1 after reset deassertion (queue empty).
  - mem_resp_valid = 0; mem_resp_data = 0.
  - Queue empty; FSM in IDLE; wait counter = 0.
  - Backing array is not reset; contents are retained across reset.
- Handshake:
  - A request is accepted on a rising edge where mem_req_valid && mem_req_ready.
  - mem_req_ready = !queue_full, registered from queue state.
  - There is no same-cycle bypass when the queue is full: with a full queue, ready stays 0 even if a dequeue happens that cycle.
- Queue: FIFO of {rw, addr, data}, QUEUE_DEPTH entries.
  - Read/write pointers carry one extra wrap bit.
  - full = pointers differ only in the wrap bit; empty = pointers equal.
  - Simultaneous enqueue and dequeue when not full and not empty: occupancy is unchanged.
- FSM:
  - IDLE: if the queue is non-empty, pop the head into the service register, load count = LATENCY, go to WAIT.
  - WAIT: count decrements each cycle. When count == 1, transition to DONE on the next edge. On that same edge:
    - read: resp register <= array[idx];
    - write: array[idx] <= data.
  - DONE, one cycle:
    - read: mem_resp_valid = 1 and mem_resp_data = resp register;
    - write: no response.
    - Then go to IDLE.
- Index: idx = addr[$clog2(MEM_LINES)-1:0]. Upper address bits are ignored, so addresses alias modulo MEM_LINES.
- Latency: a request accepted at edge T into an empty queue with the FSM in IDLE gets its read response in the cycle beginning at edge T+LATENCY+2. Sustained throughput is one request per LATENCY+2 cycles.
- Ordering:
  - Requests complete strictly in order.
  - A read after a write to the same idx returns the written data, including back-to-back requests.
- mem_resp_valid is 0 in every cycle except the DONE cycle of a read. mem_resp_data holds its last value when valid is 0.
- Reset mid-operation:
  - Queue is flushed, FSM goes to IDLE, and any in-flight or queued request is discarded.
  - A write not yet committed at the WAIT→DONE edge is lost; already-committed array contents remain.

Optional Feature:
- Macro: MAIN_MEM_STATS_EN.
- Defined: adds three output ports, each reset to 0 and saturating at all-ones:
  - stat_reads, 32 bits: increments on each read DONE.
  - stat_writes, 32 bits: increments on each write commit.
  - stat_stall_cycles, 32 bits: increments on each cycle with mem_req_valid && !mem_req_ready.
- Undefined: no ports, no counter logic; behaviour is otherwise identical.

Test Plan:
- Write then read, LATENCY=4: write addr 0x10 with data 0xA5.., then read addr 0x10 → a single mem_resp_valid pulse with data 0xA5.. at 6 cycles after the read is accepted into the drained queue.
- Back-to-back read-after-write, same address: write 0x20=0x1234 and read 0x20 on consecutive cycles → read returns 0x1234; no response is produced for the write.
- Queue full: hold valid with 5 reads, QUEUE_DEPTH=4, FSM busy → ready drops to 0 after 4 accepts; the 5th is accepted only after the first dequeue; 5 responses arrive in order.
- Aliasing, MEM_LINES=1024: write addr 0x005 = 0xBEEF, then read addr 0x405 → returns 0xBEEF.
- Reset mid-WAIT: assert reset_n=0 during a pending write to 0x30 (prior value 0x0) → ready=1 and resp_valid=0 immediately; a later read of 0x30 returns 0x0.
- With MAIN_MEM_STATS_EN: 3 reads, 2 writes and 7 stall cycles → stat_reads=3, stat_writes=2, stat_stall_cycles=7.

Source files
------------

// File: rtl/main_mem.sv
// main_mem: in-order line-granular backing store behind the L2 miss/writeback stream.
// Latency: read response LATENCY+2 cycles after acceptance into an idle, empty queue.
// Backpressure: mem_req_ready drops while the QUEUE_DEPTH-entry request FIFO is full.
// Optional: define MAIN_MEM_STATS_EN for saturating read/write/stall counters.

`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 4
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 128
`endif

// main_mem_fifo: generic pointer FIFO with wrap bits.
// Latency: data written at an edge is visible at pop_dat from the next cycle.
// Backpressure: push ignored while full; pop ignored while empty.
module main_mem_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] store_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;
  assign pop_dat = store_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; push and pop are independent so simultaneous ops keep occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers; reset flushes the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end
endmodule

module main_mem #(
  parameter int MEM_LINES   = 1024,
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                mem_req_valid,
  input  logic                                mem_req_rw,
  input  logic [`ADDR_BITS-`OFFSET_BITS-1:0]  mem_req_addr,
  input  logic [`CACHELINE_BITS-1:0]          mem_req_data,
  output logic                                mem_req_ready,
  output logic                                mem_resp_valid,
  output logic [`CACHELINE_BITS-1:0]          mem_resp_data
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [31:0]                         stat_reads,
  output logic [31:0]                         stat_writes,
  output logic [31:0]                         stat_stall_cycles
`endif
);
  localparam int LA = `ADDR_BITS - `OFFSET_BITS;
  localparam int CL = `CACHELINE_BITS;
  localparam int IW = $clog2(MEM_LINES);
  localparam int CW = $clog2(LATENCY + 1);

  typedef struct packed {
    logic          rw;
    logic [IW-1:0] idx;
    logic [CL-1:0] data;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  req_t          req_in;
  req_t          head;
  logic          q_full;
  logic          q_empty;
  logic          pop;
  logic          unused_addr_bits;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  req_t          svc_q, svc_d;
  logic          resp_vld_q, resp_vld_d;
  logic [CL-1:0] resp_dat_q, resp_dat_d;
  logic          avail_q, avail_d;
  logic          mem_we;
  logic [CL-1:0] mem_q [MEM_LINES];

  // Only the low index bits select a line; higher address bits alias.
  assign unused_addr_bits = ^mem_req_addr[LA-1:IW];
  assign req_in.rw   = mem_req_rw;
  assign req_in.idx  = mem_req_addr[IW-1:0];
  assign req_in.data = mem_req_data;

  main_mem_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_q (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (mem_req_valid),
    .push_dat (req_in),
    .pop_rdy  (pop),
    .pop_dat  (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Ready comes straight from the pointer flops: no bypass when a pop frees a slot.
  assign mem_req_ready  = !q_full;
  assign mem_resp_valid = resp_vld_q;
  assign mem_resp_data  = resp_dat_q;
  assign mem_we         = (state_q == S_WAIT) && (count_q == CW'(1)) && svc_q.rw;

  // Service FSM next state. Queue status is registered (avail_q) before the FSM
  // acts on it, so a fresh request sits one cycle in the queue before being popped.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    svc_d      = svc_q;
    resp_vld_d = 1'b0;
    resp_dat_d = resp_dat_q;
    avail_d    = !q_empty;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (avail_q && !q_empty) begin
          pop     = 1'b1;
          svc_d   = head;
          count_d = CW'(LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_DONE;
          if (!svc_q.rw) begin
            resp_vld_d = 1'b1;
            resp_dat_d = mem_q[svc_q.idx];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and registered response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      svc_q      <= '0;
      resp_vld_q <= 1'b0;
      resp_dat_q <= '0;
      avail_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      svc_q      <= svc_d;
      resp_vld_q <= resp_vld_d;
      resp_dat_q <= resp_dat_d;
      avail_q    <= avail_d;
    end
  end

  // Backing array: never reset, so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[svc_q.idx] <= svc_q.data;
  end

`ifdef MAIN_MEM_STATS_EN
  logic [31:0] stat_reads_q, stat_reads_d;
  logic [31:0] stat_writes_q, stat_writes_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Saturating event counters: read DONE cycles, write commits, blocked request cycles.
  always_comb begin
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    stat_stall_d  = stat_stall_q;
    if (resp_vld_q && (stat_reads_q != '1))                    stat_reads_d  = stat_reads_q + 32'd1;
    if (mem_we && (stat_writes_q != '1))                       stat_writes_d = stat_writes_q + 32'd1;
    if (mem_req_valid && !mem_req_ready && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_reads        = stat_reads_q;
  assign stat_writes       = stat_writes_q;
  assign stat_stall_cycles = stat_stall_q;
`endif
endmodule
